// File: rtl/heartbeat_gen.sv
// rtl/heartbeat_gen.sv - multi-channel programmable heartbeat / strobe generator
//
// Each channel runs an N-bit period counter (period = P+1 cycles) and drives
// one registered output in OFF, PULSE, TOGGLE or PWM mode. Configuration
// writes are shadowed per channel and become active only at that channel's
// counter wrap, while the channel is OFF, or on a global sync, so a change
// never truncates or stretches a high or low phase.
//
// Ports:
//   clk          rising-edge clock
//   nreset       asynchronous active-low reset
//   sync         restart all running channels' counters together
//   cfg_we       configuration write strobe
//   cfg_ch       target channel of the write (values >= CH are ignored)
//   cfg_mode     0=OFF 1=PULSE 2=TOGGLE 3=PWM
//   cfg_period   terminal count P
//   cfg_high     PWM high count H
//   out          registered channel outputs
//   cfg_pending  per-channel flag: a written configuration awaits its apply
module heartbeat_gen #(
    parameter int            N          = 8,
    parameter int            CH         = 4,
    parameter logic [1:0]    RST_MODE   = 2'd1,
    parameter logic [N-1:0]  RST_PERIOD = {N{1'b1}},
    parameter logic [N-1:0]  RST_HIGH   = '0,
    localparam int           CW         = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          sync,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_ch,
    input  logic [1:0]    cfg_mode,
    input  logic [N-1:0]  cfg_period,
    input  logic [N-1:0]  cfg_high,
    output logic [CH-1:0] out,
    output logic [CH-1:0] cfg_pending
);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_PULSE  = 2'd1,
        MODE_TOGGLE = 2'd2,
        MODE_PWM    = 2'd3
    } mode_t;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        mode_t        mode_a;
        mode_t        mode_p;
        logic [N-1:0] per_a;
        logic [N-1:0] hi_a;
        logic [N-1:0] per_p;
        logic [N-1:0] hi_p;
        logic [N-1:0] cnt;
        logic         pend;
        logic         tog;
        logic         out_q;

        logic         sel;
        logic         tc;
        logic         is_off;
        logic         apply;
        logic         tog_run;
        logic         out_nxt;

        // Channel indices >= CH never equal a generated index, so an
        // out-of-range cfg_ch selects nothing.
        assign sel    = cfg_we && (cfg_ch == CW'(c));
        assign tc     = (cnt == per_a);
        assign is_off = (mode_a == MODE_OFF);
        // pend is the registered flag, so a write landing in this very
        // cycle is not applied at this edge.
        assign apply  = pend && (tc || is_off || sync);

        // Toggle state as it would evolve under the current active mode.
        assign tog_run = sync ? 1'b0 : (tog ^ tc);

        always_comb begin
            out_nxt = 1'b0;
            case (mode_a)
                MODE_OFF:    out_nxt = 1'b0;
                MODE_PULSE:  out_nxt = tc;
                MODE_TOGGLE: out_nxt = tog_run;
                MODE_PWM:    out_nxt = (cnt < hi_a);
                default:     out_nxt = 1'b0;
            endcase
        end

        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                mode_a <= mode_t'(RST_MODE);
                per_a  <= RST_PERIOD;
                hi_a   <= RST_HIGH;
                mode_p <= mode_t'(RST_MODE);
                per_p  <= RST_PERIOD;
                hi_p   <= RST_HIGH;
                cnt    <= '0;
                pend   <= 1'b0;
                tog    <= 1'b0;
                out_q  <= 1'b0;
            end else begin
                // The output always follows the rule of the mode active in
                // this cycle, even on the edge that switches configuration.
                out_q <= out_nxt;

                if (is_off || sync || tc) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end

                // Toggle state only carries meaning in TOGGLE mode.
                if (apply && (mode_p != MODE_TOGGLE)) begin
                    tog <= 1'b0;
                end else if (mode_a == MODE_TOGGLE) begin
                    tog <= tog_run;
                end else begin
                    tog <= 1'b0;
                end

                if (apply) begin
                    mode_a <= mode_p;
                    per_a  <= per_p;
                    hi_a   <= hi_p;
                    cnt    <= '0;
                end

                // A new write overrides the clear of an apply in the same
                // cycle: the fresh values wait for the next apply point.
                if (sel) begin
                    mode_p <= mode_t'(cfg_mode);
                    per_p  <= cfg_period;
                    hi_p   <= cfg_high;
                    pend   <= 1'b1;
                end else if (apply) begin
                    pend   <= 1'b0;
                end
            end
        end

        assign out[c]         = out_q;
        assign cfg_pending[c] = pend;
    end

endmodule

// File: tb/tb_heartbeat_gen.sv
// tb/tb_heartbeat_gen.sv - self-checking bench for heartbeat_gen
module tb_heartbeat_gen;

    localparam int N  = 8;
    localparam int CH = 5;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          nreset;
    logic          sync;
    logic          cfg_we;
    logic [CW-1:0] cfg_ch;
    logic [1:0]    cfg_mode;
    logic [N-1:0]  cfg_period;
    logic [N-1:0]  cfg_high;
    logic [CH-1:0] out;
    logic [CH-1:0] cfg_pending;

    int n_cmp = 0;
    int n_bad = 0;

    heartbeat_gen #(.N(N), .CH(CH)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .sync       (sync),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .out        (out),
        .cfg_pending(cfg_pending)
    );

    always #5 clk = ~clk;

    // Reference model: per channel, the phase within the current period,
    // the active and shadowed configuration and the toggle level.
    int m_mode[CH], m_p[CH], m_h[CH], m_ph[CH], m_tog[CH], m_out[CH];
    int s_mode[CH], s_p[CH], s_h[CH], s_pend[CH];

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_mode[c] = 1; m_p[c] = 255; m_h[c] = 0;
            s_mode[c] = 1; s_p[c] = 255; s_h[c] = 0; s_pend[c] = 0;
            m_ph[c] = 0; m_tog[c] = 0; m_out[c] = 0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            int wrap, take, trun;
            wrap = (m_ph[c] == m_p[c]) ? 1 : 0;
            take = (s_pend[c] != 0) && (wrap != 0 || m_mode[c] == 0 || sync);
            trun = sync ? 0 : (m_tog[c] ^ wrap);
            case (m_mode[c])
                1:       m_out[c] = wrap;
                2:       m_out[c] = trun;
                3:       m_out[c] = (m_ph[c] < m_h[c]) ? 1 : 0;
                default: m_out[c] = 0;
            endcase
            m_tog[c] = (m_mode[c] == 2) ? trun : 0;
            if (m_mode[c] == 0 || sync) m_ph[c] = 0;
            else                        m_ph[c] = (m_ph[c] + 1) % (m_p[c] + 1);
            if (take) begin
                m_mode[c] = s_mode[c]; m_p[c] = s_p[c]; m_h[c] = s_h[c];
                m_ph[c] = 0; s_pend[c] = 0;
                if (s_mode[c] != 2) m_tog[c] = 0;
            end
            if (cfg_we && int'(cfg_ch) == c) begin
                s_mode[c] = int'(cfg_mode); s_p[c] = int'(cfg_period);
                s_h[c] = int'(cfg_high); s_pend[c] = 1;
            end
        end
    endtask

    function automatic logic [CH-1:0] exp_out();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = (m_out[c] != 0);
        return v;
    endfunction

    function automatic logic [CH-1:0] exp_pend();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = (s_pend[c] != 0);
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("out", 32'(out), 32'(exp_out()));
        check("pending", 32'(cfg_pending), 32'(exp_pend()));
    endtask

    task automatic wr(input int c, input int m, input int p, input int h);
        cfg_ch = CW'(c); cfg_mode = 2'(m); cfg_period = N'(p); cfg_high = N'(h);
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_apply(input int c, input int bound);
        for (int i = 0; i < bound && cfg_pending[c]; i++) tick();
        check("apply_seen", 32'(cfg_pending[c]), 32'd0);
    endtask

    task automatic wait_phase(input int c, input int ph, input int bound);
        for (int i = 0; i < bound && m_ph[c] != ph; i++) tick();
        check("phase_reached", m_ph[c], ph);
    endtask

    initial begin
        int cnt_hi, trans;
        logic prev;

        nreset = 1'b0; sync = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_mode = '0; cfg_period = '0; cfg_high = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", 32'(out), 32'd0);
        check("rst_pend", 32'(cfg_pending), 32'd0);
        nreset = 1'b1;

        // Legacy beat: all channels high only between edges 256 and 257.
        for (int k = 1; k <= 600; k++) begin
            tick();
            if (k == 255) check("beat_pre", 32'(out), 32'd0);
            if (k == 256) check("beat", 32'(out), 32'h1f);
            if (k == 257) check("beat_post", 32'(out), 32'd0);
            if (k == 512) check("beat_rep", 32'(out), 32'h1f);
        end

        // PWM 3 high / 7 low, then H=0 gives steady low.
        wr(1, 3, 9, 3);
        check("pend_set", 32'(cfg_pending[1]), 32'd1);
        wait_apply(1, 300);
        cnt_hi = 0;
        repeat (10) begin tick(); cnt_hi += int'(out[1]); end
        check("pwm_high", cnt_hi, 3);
        wr(1, 3, 9, 0);
        wait_apply(1, 20);
        cnt_hi = 0;
        repeat (20) begin tick(); cnt_hi += int'(out[1]); end
        check("pwm_h0", cnt_hi, 0);

        // Toggle P=4, then P=0; PULSE P=0.
        wr(2, 2, 4, 0);
        wait_apply(2, 300);
        cnt_hi = 0;
        repeat (20) begin tick(); cnt_hi += int'(out[2]); end
        check("tog_duty", cnt_hi, 10);
        wr(2, 2, 0, 0);
        wait_apply(2, 20);
        trans = 0; prev = out[2];
        repeat (10) begin tick(); if (out[2] != prev) trans++; prev = out[2]; end
        check("tog_p0", trans, 10);
        wr(3, 1, 0, 0);
        wait_apply(3, 300);
        cnt_hi = 0;
        repeat (10) begin tick(); cnt_hi += int'(out[3]); end
        check("pulse_p0", cnt_hi, 10);

        // Deferred apply on ch0 (P=255 since reset).
        wait_phase(0, 100, 300);
        wr(0, 1, 3, 0);
        repeat (150) tick();
        check("defer_hold", 32'(cfg_pending[0]), 32'd1);
        wait_apply(0, 20);
        wait_phase(0, 3, 10);
        wr(0, 1, 5, 0);
        repeat (3) tick();
        check("tc_write_hold", 32'(cfg_pending[0]), 32'd1);
        tick();
        check("tc_write_apply", 32'(cfg_pending[0]), 32'd0);
        wr(0, 1, 7, 0);
        wr(0, 1, 2, 0);
        wait_apply(0, 20);
        cnt_hi = 0;
        repeat (9) begin tick(); cnt_hi += int'(out[0]); end
        check("last_write_wins", cnt_hi, 3);

        // sync alignment and an out-of-range channel write.
        wr(0, 1, 9, 0);
        wr(1, 1, 19, 0);
        wr(4, 1, 29, 0);
        wait_apply(0, 40);
        wait_apply(1, 40);
        wait_apply(4, 300);
        repeat ($urandom_range(5, 30)) tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        repeat (20) tick();
        check("sync_align", 32'({out[0], out[1]}), 32'd3);
        wr(5, 3, 1, 1);
        check("illegal_ch", 32'(cfg_pending), 32'd0);
        repeat (40) tick();

        // Randomized writes and syncs against the model.
        repeat (2000) begin
            cfg_we     = ($urandom_range(0, 7) == 0);
            cfg_ch     = CW'($urandom_range(0, 7));
            cfg_mode   = 2'($urandom);
            cfg_period = N'($urandom_range(0, 12));
            cfg_high   = N'($urandom_range(0, 14));
            sync       = ($urandom_range(0, 63) == 0);
            tick();
        end
        cfg_we = 1'b0; sync = 1'b0;

        // Async reset mid-PWM with a pending write.
        wr(1, 3, 9, 4);
        wait_apply(1, 300);
        wr(1, 2, 5, 0);
        repeat (3) tick();
        #3;
        nreset = 1'b0;
        #1;
        check("arst_out", 32'(out), 32'd0);
        check("arst_pend", 32'(cfg_pending), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        nreset = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (k == 256) check("arst_beat", 32'(out), 32'h1f);
        end
        check("arst_lost", 32'(cfg_pending), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
